// File: rtl/axis_image_vip_pkg.sv
// Shared types and constants for the frame arbiter slice.
package axis_image_vip_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } arb_state_e;

   // err_o bit positions
   localparam int ERR_TIMEOUT = 0;
   localparam int ERR_SOF     = 1;
   localparam int ERR_LINE    = 2;

   // Width of a counter holding 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after ptr_i, wrapping.
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          hit_o
);

   logic [IW-1:0] k_c;

   // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      hit_o    = 1'b0;
      k_c      = '0;
      for (int i = 1; i <= N; i++) begin
         k_c = IW'((int'(ptr_i) + i) % N);
         if (!hit_o && req_i[k_c]) begin
            hit_o         = 1'b1;
            idx_o         = k_c;
            onehot_o[k_c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin AXI-Stream arbiter.
// A source wins only on a start-of-frame beat and keeps the sink until
// LINES_PER_FRAME end-of-line beats have passed or it stalls too long.
// Optional line/frame structure checking: define AXIS_FRAME_CHECK_EN.
module axis_frame_arbiter
   import axis_image_vip_pkg::*;
#(
   parameter int NUM_SRC         = 2,
   parameter int DATA_BITS       = 8,
   parameter int LINES_PER_FRAME = 4,
   parameter int PIXELS_PER_LINE = 4,
   parameter int TIMEOUT_CYCLE   = 1000
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [NUM_SRC*DATA_BITS-1:0] s_data_i,
   input  logic [NUM_SRC-1:0]           s_valid_i,
   output logic [NUM_SRC-1:0]           s_ready_o,
   input  logic [NUM_SRC-1:0]           s_last_i,
   input  logic [NUM_SRC-1:0]           s_user_i,
   output logic [DATA_BITS-1:0]         m_data_o,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   output logic                         m_last_o,
   output logic                         m_user_o,
   output logic [$clog2(NUM_SRC)-1:0]   grant_o,
   output logic                         busy_o,
   output logic [15:0]                  frame_cnt_o,
   output logic [2:0]                   err_o
);

   localparam int GW = clog2_min1(NUM_SRC);
   localparam int LW = clog2_min1(LINES_PER_FRAME);
   localparam int TW = clog2_min1(TIMEOUT_CYCLE);

   if (NUM_SRC < 2 || LINES_PER_FRAME < 1 || PIXELS_PER_LINE < 1 || TIMEOUT_CYCLE < 1) begin : g_bad_cfg
      $error("axis_frame_arbiter: illegal parameter set");
   end

   arb_state_e           state_q, state_d;
   logic [GW-1:0]        grant_q, grant_d, ptr_q, ptr_d;
   logic [LW-1:0]        line_q, line_d, lc_c;
   logic [TW-1:0]        stall_q, stall_d;
   logic [15:0]          frame_q, frame_d;
   logic [2:0]           err_q, err_d;
   logic [DATA_BITS-1:0] m_data_q, m_data_d;
   logic                 m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;
`ifdef AXIS_FRAME_CHECK_EN
   logic [15:0]          pix_q, pix_d, pc_c;
`endif

   logic [DATA_BITS-1:0] sel_data;
   logic                 sel_valid, sel_last, sel_user;
   logic [NUM_SRC-1:0]   pick_oh;
   logic [GW-1:0]        pick_idx;
   logic                 pick_hit, out_free, accept;

   rr_picker #(.N(NUM_SRC), .IW(GW)) u_pick (
      .req_i    (s_valid_i & s_user_i),
      .ptr_i    (ptr_q),
      .onehot_o (pick_oh),
      .idx_o    (pick_idx),
      .hit_o    (pick_hit)
   );

   assign out_free = !m_valid_q || m_ready_i;
   assign accept   = (state_q == STREAM) && sel_valid && out_free;

   // Mux the granted source's beat.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_user  = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (grant_q == GW'(k)) begin
            sel_data  = s_data_i[k*DATA_BITS +: DATA_BITS];
            sel_valid = s_valid_i[k];
            sel_last  = s_last_i[k];
            sel_user  = s_user_i[k];
         end
      end
   end

   // IDLE swallows non-SOF beats to realign; STREAM opens only the granted source.
   // Nothing is accepted while reset is held, so sources keep their beats.
   always_comb begin
      s_ready_o = '0;
      if (rstn_i) begin
         if (state_q == IDLE) begin
            s_ready_o = ~s_user_i;
         end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
               s_ready_o[k] = (grant_q == GW'(k)) && out_free;
            end
         end
      end
   end

   // Next state: output register, arbitration, line/frame counting, timeout.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      line_d    = line_q;
      stall_d   = stall_q;
      frame_d   = frame_q;
      err_d     = err_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_user_d  = m_user_q;
      lc_c      = line_q;
`ifdef AXIS_FRAME_CHECK_EN
      pix_d     = pix_q;
      pc_c      = pix_q;
`endif
      if (out_free) begin
         m_valid_d = accept;
         if (accept) begin
            m_data_d = sel_data;
            m_last_d = sel_last;
            m_user_d = sel_user;
         end
      end
      case (state_q)
         IDLE: begin
            stall_d = '0;
            if (pick_hit) begin
               grant_d = pick_idx;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               stall_d = '0;
`ifdef AXIS_FRAME_CHECK_EN
               // SOF inside a frame: flag it and treat the beat as a fresh frame start.
               if (sel_user && (lc_c != '0 || pc_c != '0)) begin
                  err_d[ERR_SOF] = 1'b1;
                  lc_c = '0;
                  pc_c = '0;
               end
`endif
               if (sel_last) begin
`ifdef AXIS_FRAME_CHECK_EN
                  if (pc_c != 16'(PIXELS_PER_LINE - 1)) err_d[ERR_LINE] = 1'b1;
                  pix_d = '0;
`endif
                  if (lc_c == LW'(LINES_PER_FRAME - 1)) begin
                     line_d  = '0;
                     frame_d = frame_q + 16'd1;
                     ptr_d   = grant_q;
                     state_d = IDLE;
                  end else begin
                     line_d = lc_c + 1'b1;
                  end
               end else begin
                  line_d = lc_c;
`ifdef AXIS_FRAME_CHECK_EN
                  if (pc_c != '1) pix_d = pc_c + 16'd1;
`endif
               end
            end else if (!sel_valid) begin
               // Only a silent source stalls; sink backpressure holds the count.
               if (stall_q == TW'(TIMEOUT_CYCLE - 1)) begin
                  err_d[ERR_TIMEOUT] = 1'b1;
                  line_d  = '0;
                  stall_d = '0;
                  ptr_d   = grant_q;
                  state_d = IDLE;
`ifdef AXIS_FRAME_CHECK_EN
                  pix_d   = '0;
`endif
               end else begin
                  stall_d = stall_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; async reset truncates any frame in flight.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         line_q    <= '0;
         stall_q   <= '0;
         frame_q   <= '0;
         err_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_user_q  <= 1'b0;
`ifdef AXIS_FRAME_CHECK_EN
         pix_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         line_q    <= line_d;
         stall_q   <= stall_d;
         frame_q   <= frame_d;
         err_q     <= err_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_user_q  <= m_user_d;
`ifdef AXIS_FRAME_CHECK_EN
         pix_q     <= pix_d;
`endif
      end
   end

   assign m_data_o    = m_data_q;
   assign m_valid_o   = m_valid_q;
   assign m_last_o    = m_last_q;
   assign m_user_o    = m_user_q;
   assign grant_o     = grant_q;
   assign busy_o      = (state_q == STREAM);
   assign frame_cnt_o = frame_q;
   assign err_o       = err_q;

endmodule
